// File: rtl/bin_to_bcd8_pkg.sv
// bin_to_bcd8_pkg
// Shared constants, state encoding and the leading-zero blanking helper
// for the 8-digit binary-to-BCD converter.
package bin_to_bcd8_pkg;

    localparam int          N_DIGITS   = 8;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam logic [31:0] MAX_DEC    = 32'd99_999_999;
    localparam logic [31:0] SAT_BCD    = 32'h99999999;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    // Replace every zero digit above the most significant nonzero digit
    // with BLANK_CODE. Digit 0 is never blanked, so zero shows as "0".
    function automatic logic [31:0] blank_lz(input logic [31:0] v);
        logic [31:0] r;
        logic        lead;
        r    = v;
        lead = 1'b1;
        for (int d = N_DIGITS - 1; d >= 1; d--) begin
            if (lead && (v[d*4 +: 4] == 4'd0)) begin
                r[d*4 +: 4] = BLANK_CODE;
            end else begin
                lead = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bin_to_bcd8_add3.sv
// bcd_add3
// Combinational double-dabble digit corrector: a digit of 5 or more gets
// +3 so that the following left shift carries correctly into the next
// decimal digit. 4-bit result; any carry out is dropped.
// Ports:
//   din   in  4  BCD digit before correction
//   dout  out 4  corrected digit
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? (din + 4'd3) : din;

endmodule

// File: rtl/bin_to_bcd8.sv
// bin_to_bcd8
// Sequential binary-to-BCD converter (shift-and-add-3, one input bit per
// clock) producing the packed 8-digit BCD word for the seven-segment
// display multiplexer. The result is held stable between conversions.
//
// Optional feature: define BIN_TO_BCD8_BLANK_LZ_EN to replace leading zero
// digits with 4'hF (rendered blank by the display decoder). The saturated
// overflow value is never blanked.
//
// Ports:
//   clk       in  1     system clock
//   rst       in  1     synchronous, active-high reset
//   start     in  1     conversion request, sampled only in IDLE
//   bin       in  IN_W  unsigned operand, captured on the accepted start
//   busy      out 1     high while a conversion is in progress
//   done      out 1     one-cycle pulse coincident with the bcd update
//   bcd       out 32    packed BCD, digit 7 in [31:28] .. digit 0 in [3:0]
//   overflow  out 1     last accepted operand exceeded 99,999,999
//
// Handshake: a request is taken on any clock edge where start=1 and the
// converter is in IDLE (busy=0); requests at other times are dropped, not
// queued. done pulses for exactly one cycle when bcd/overflow update.
module bin_to_bcd8
    import bin_to_bcd8_pkg::*;
#(
    parameter int IN_W = 27
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [IN_W-1:0] bin,
    output logic            busy,
    output logic            done,
    output logic [31:0]     bcd,
    output logic            overflow
);

    state_t state;
    state_t state_n;

    logic [IN_W-1:0] shreg;
    logic [31:0]     scratch;
    logic [31:0]     scratch_adj;
    logic [5:0]      cnt;
    logic            ovf_pend;
    logic [31:0]     bin_ext;
    logic [31:0]     result;

    assign bin_ext = 32'(bin);

    // Per-digit add-3 correction applied before every shift.
    genvar g;
    generate
        for (g = 0; g < N_DIGITS; g++) begin : g_add3
            bcd_add3 u_add3 (
                .din  (scratch[g*4 +: 4]),
                .dout (scratch_adj[g*4 +: 4])
            );
        end
    endgenerate

`ifdef BIN_TO_BCD8_BLANK_LZ_EN
    assign result = ovf_pend ? SAT_BCD : blank_lz(scratch);
`else
    assign result = ovf_pend ? SAT_BCD : scratch;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = SHIFT;
            SHIFT:   if (cnt == 6'd1) state_n = FINISH;
            FINISH:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg    <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            bcd      <= '0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg    <= bin;
                        scratch  <= '0;
                        cnt      <= 6'(IN_W);
                        ovf_pend <= (bin_ext > MAX_DEC);
                        busy     <= 1'b1;
                    end
                end
                SHIFT: begin
                    // Carry out of digit 7 falls off the top here.
                    scratch <= {scratch_adj[30:0], shreg[IN_W-1]};
                    shreg   <= {shreg[IN_W-2:0], 1'b0};
                    cnt     <= cnt - 6'd1;
                end
                FINISH: begin
                    bcd      <= result;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd8.sv
// tb_bin_to_bcd8
// Directed self-checking bench for bin_to_bcd8 (default IN_W=27).
// Honours BIN_TO_BCD8_BLANK_LZ_EN for the expected display words.
module tb_bin_to_bcd8;

    logic        clk;
    logic        rst;
    logic        start;
    logic [26:0] bin;
    logic        busy;
    logic        done;
    logic [31:0] bcd;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    bin_to_bcd8 #(.IN_W(27)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .bin      (bin),
        .busy     (busy),
        .done     (done),
        .bcd      (bcd),
        .overflow (overflow)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected display word for a small value; blanking variant hand-coded.
    // Driver: one conversion, full timing and result checks.
    task automatic do_conv(input string tag, input logic [26:0] v,
                           input logic [31:0] exp_bcd, input logic exp_ovf);
        int n;
        @(negedge clk);
        start = 1'b1;
        bin   = v;
        @(negedge clk);              // accepting edge E has passed
        start = 1'b0;
        bin   = 27'($urandom_range(0, 1000));
        chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(n), 32'd28);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_bcd"}, bcd, exp_bcd);
        chk({tag, "_ovf"}, 32'(overflow), 32'(exp_ovf));
        @(negedge clk);
        chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int n;
        int dones;
        int changes;
        logic [31:0] held;
        logic [31:0] seen;

        rst   = 1'b1;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", bcd, 32'h0);
        chk("rst_ovf", 32'(overflow), 32'd0);

        // Zero
`ifdef BIN_TO_BCD8_BLANK_LZ_EN
        do_conv("zero", 27'd0, 32'hFFFFFFF0, 1'b0);
`else
        do_conv("zero", 27'd0, 32'h00000000, 1'b0);
`endif

        // Full 8-digit value, then 100 idle cycles with bin wiggling
        do_conv("v12345678", 27'd12_345_678, 32'h12345678, 1'b0);
        held    = bcd;
        changes = 0;
        for (int i = 0; i < 100; i++) begin
            bin = 27'($urandom_range(0, 99_999_999));
            @(negedge clk);
            if (bcd !== held || done !== 1'b0) changes++;
        end
        chk("hold_100", 32'(changes), 32'd0);

        // Upper boundary and saturation
        do_conv("max_dec", 27'd99_999_999, 32'h99999999, 1'b0);
        do_conv("over_max", 27'd100_000_000, 32'h99999999, 1'b1);

        // Small value with blanking
`ifdef BIN_TO_BCD8_BLANK_LZ_EN
        do_conv("v42", 27'd42, 32'hFFFFFF42, 1'b0);
`else
        do_conv("v42", 27'd42, 32'h00000042, 1'b0);
`endif

        // Start during SHIFT is ignored
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        start = 1'b1;
        bin   = 27'd77;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        seen  = 32'hDEAD_BEEF;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                dones++;
                seen = bcd;
            end
        end
        chk("ign_done_count", 32'(dones), 32'd1);
`ifdef BIN_TO_BCD8_BLANK_LZ_EN
        chk("ign_bcd", seen, 32'hFFFFFFF5);
`else
        chk("ign_bcd", seen, 32'h00000005);
`endif
        chk("ign_ovf", 32'(overflow), 32'd0);

        // Reset mid-conversion
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd4321;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_bcd", bcd, 32'h0);
        chk("abort_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
`ifdef BIN_TO_BCD8_BLANK_LZ_EN
        do_conv("v4321", 27'd4321, 32'hFFFF4321, 1'b0);
`else
        do_conv("v4321", 27'd4321, 32'h00004321, 1'b0);
`endif

        // start held high: back-to-back accepts at E+IN_W+2
        @(negedge clk);
        start = 1'b1;
        bin   = 27'd100_000_123;
        @(negedge clk);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_first_cycles", 32'(n), 32'd28);
        chk("b2b_first_done", 32'(done), 32'd1);
        chk("b2b_first_bcd", bcd, 32'h99999999);
        chk("b2b_first_ovf", 32'(overflow), 32'd1);
        bin = 27'd7;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_reaccept", 32'(busy), 32'd1);
        chk("b2b_done_low", 32'(done), 32'd0);
        chk("b2b_hold_bcd", bcd, 32'h99999999);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        chk("b2b_second_cycles", 32'(n), 32'd28);
        chk("b2b_second_done", 32'(done), 32'd1);
`ifdef BIN_TO_BCD8_BLANK_LZ_EN
        chk("b2b_second_bcd", bcd, 32'hFFFFFFF7);
`else
        chk("b2b_second_bcd", bcd, 32'h00000007);
`endif
        chk("b2b_second_ovf", 32'(overflow), 32'd0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
